// File: rtl/gsm_pkg.sv
// Shared state encoding, byte constants and script ROM contents for the GSM command scheduler.
// The package is the same whether or not GSM_SCHED_TIMEOUT_EN is defined.
package gsm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } gsm_state_e;

    localparam logic [7:0] GSM_CR    = 8'h0D;
    localparam logic [7:0] GSM_EOS   = 8'h00;
    localparam logic [7:0] GSM_CTRLZ = 8'h1A;

    localparam int MAX_REQ = 4;
    localparam logic [7:0] SCRIPT_BASE [MAX_REQ] = '{8'h00, 8'h10, 8'h20, 8'h30};

    // One AT script per requester; every script ends with the GSM_EOS sentinel.
    function automatic logic [7:0] script_byte(input logic [31:0] addr);
        logic [7:0] b;
        case (addr)
            32'h00: b = 8'h41;
            32'h01: b = 8'h54;
            32'h02: b = GSM_CR;
            32'h10: b = 8'h41;
            32'h11: b = 8'h54;
            32'h12: b = 8'h49;
            32'h13: b = GSM_CR;
            32'h14: b = GSM_CTRLZ;
            32'h20: b = 8'h41;
            32'h21: b = 8'h54;
            32'h22: b = 8'h48;
            32'h23: b = GSM_CR;
            32'h30: b = 8'h41;
            32'h31: b = 8'h54;
            32'h32: b = 8'h41;
            32'h33: b = GSM_CR;
            default: b = GSM_EOS;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/gsm_script_rom.sv
// Script ROM, 2^ROM_AW x 8, one-cycle synchronous read.
// The contents come from gsm_pkg::script_byte.
module gsm_script_rom
    import gsm_pkg::*;
#(
    parameter int ROM_AW = 8
) (
    input  logic              clk,
    input  logic [ROM_AW-1:0] addr,
    output logic [7:0]        rd_data
);

    logic [7:0] rd_data_d;
    logic [7:0] rd_data_q;

    always_comb begin
        rd_data_d = script_byte(32'(addr));
    end

    // NOTE: the ROM read register has no reset. It is only consumed in LOAD, which always follows a FETCH that
    // loaded it, so a reset value would never be observed and would only block mapping onto a block ROM.
    always_ff @(posedge clk) begin
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/gsm_cmd_scheduler.sv
// Round-robin scheduler that streams per-requester AT scripts to the UART TX and enforces the modem settle gap.
// Define GSM_SCHED_TIMEOUT_EN to abandon a script when tx_ready stalls for TIMEOUT_CYC cycles.
module gsm_cmd_scheduler
    import gsm_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int DELAY_CYC   = 12_000_000,
    parameter int ROM_AW      = 8,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic               busy,
    output logic [1:0]         grant_id,
    output logic               done,
    output logic               err,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready
);

    if (NUM_REQ < 1 || NUM_REQ > MAX_REQ || DELAY_CYC < 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("gsm_cmd_scheduler: parameter out of range");
    end

    localparam int GAP_W = (DELAY_CYC > 1) ? $clog2(DELAY_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(DELAY_CYC - 1);

    gsm_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [1:0]         rr_q, rr_d;
    logic [1:0]         grant_q, grant_d;
    logic [ROM_AW-1:0]  addr_q, addr_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               tx_valid_q, tx_valid_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [7:0]         rom_data;
    logic               arb_hit;
    logic [1:0]         arb_id;
    logic [NUM_REQ-1:0] arb_oh;
    logic [NUM_REQ-1:0] clr_req;

`ifdef GSM_SCHED_TIMEOUT_EN
    localparam int STALL_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYC - 1);
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               err_q, err_d;
`endif

    gsm_script_rom #(.ROM_AW(ROM_AW)) u_rom (
        .clk     (clk),
        .addr    (addr_q),
        .rd_data (rom_data)
    );

    // First pending requester at or after the round-robin pointer.
    always_comb begin
        arb_hit = 1'b0;
        arb_id  = '0;
        arb_oh  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!arb_hit && pending_q[i] && (i == (int'(rr_q) + k) % NUM_REQ)) begin
                    arb_hit   = 1'b1;
                    arb_id    = 2'(i);
                    arb_oh[i] = 1'b1;
                end
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path through the case can infer a latch.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        grant_d    = grant_q;
        addr_d     = addr_q;
        gap_d      = gap_q;
        busy_d     = busy_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        done_d     = 1'b0;
        clr_req    = '0;
`ifdef GSM_SCHED_TIMEOUT_EN
        stall_d    = stall_q;
        err_d      = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (arb_hit) begin
                    state_d = ST_FETCH;
                    busy_d  = 1'b1;
                    grant_d = arb_id;
                    addr_d  = ROM_AW'(SCRIPT_BASE[arb_id]);
                    rr_d    = 2'((int'(arb_id) + 1) % NUM_REQ);
                    clr_req = arb_oh;
                end
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
`ifdef GSM_SCHED_TIMEOUT_EN
                stall_d = '0;
`endif
                if (rom_data == GSM_EOS) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d    = ST_SEND;
                    tx_valid_d = 1'b1;
                    tx_data_d  = rom_data;
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    addr_d     = addr_q + ROM_AW'(1);
                    gap_d      = '0;
                    state_d    = (tx_data_q == GSM_CR) ? ST_GAP : ST_FETCH;
`ifdef GSM_SCHED_TIMEOUT_EN
                    stall_d    = '0;
                end else if (stall_q == STALL_LAST) begin
                    tx_valid_d = 1'b0;
                    busy_d     = 1'b0;
                    err_d      = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    stall_d    = stall_q + STALL_W'(1);
`endif
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_FETCH;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A new request wins over the clear, so a requester re-requesting while granted runs again.
    always_comb begin
        pending_d = (pending_q & ~clr_req) | req;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            rr_q       <= '0;
            grant_q    <= '0;
            addr_q     <= '0;
            gap_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            rr_q       <= rr_d;
            grant_q    <= grant_d;
            addr_q     <= addr_d;
            gap_q      <= gap_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

`ifdef GSM_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy     = busy_q;
    assign grant_id = grant_q;
    assign done     = done_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;

endmodule

// File: tb/tb_gsm_cmd_scheduler.sv
// Self-checking bench for gsm_cmd_scheduler: directed scenarios plus randomized requests and back-pressure,
// compared against a script-level reference model.
module tb_gsm_cmd_scheduler;

    localparam int D  = 10;
    localparam int TO = 20;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] S0 [3] = '{8'h41, 8'h54, 8'h0D};
    localparam logic [7:0] S1 [5] = '{8'h41, 8'h54, 8'h49, 8'h0D, 8'h1A};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req = 2'b00;
    logic       tx_ready = 1'b1;
    logic       busy, done, err, tx_valid;
    logic [1:0] grant_id;
    logic [7:0] tx_data;

    gsm_cmd_scheduler #(
        .NUM_REQ     (2),
        .DELAY_CYC   (D),
        .ROM_AW      (8),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .busy     (busy),
        .grant_id (grant_id),
        .done     (done),
        .err      (err),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Monitor: records every accepted byte and pulse, and counts protocol violations.
    logic [7:0] got_b [$];
    int         got_g [$];
    int         got_c [$];
    int         done_c [$];
    int         err_c [$];
    int         viol = 0;
    logic       stall_prev = 1'b0, acc_prev = 1'b0, busy_prev = 1'b0, done_prev = 1'b0;
    logic [7:0] data_prev = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
            acc_prev   = 1'b0;
            busy_prev  = 1'b0;
            done_prev  = 1'b0;
        end else begin
            if (stall_prev && !(tx_valid === 1'b1 && tx_data === data_prev)) viol++;
            if (acc_prev && tx_valid !== 1'b0) viol++;
            if (done === 1'b1 && busy === 1'b1) viol++;
            if (busy_prev && busy === 1'b0 && done !== 1'b1 && err !== 1'b1) viol++;
            if (done === 1'b1 && done_prev) viol++;
            if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
                got_b.push_back(tx_data);
                got_g.push_back(int'(grant_id));
                got_c.push_back(cyc);
            end
            if (done === 1'b1) done_c.push_back(cyc);
            if (err === 1'b1) err_c.push_back(cyc);
            stall_prev = (tx_valid === 1'b1) && (tx_ready !== 1'b1);
            acc_prev   = (tx_valid === 1'b1) && (tx_ready === 1'b1);
            data_prev  = tx_data;
            busy_prev  = (busy === 1'b1);
            done_prev  = (done === 1'b1);
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: whole scripts, served in round-robin order among the requested set.
    logic [7:0] exp_b [$];
    int         exp_g [$];
    bit         exp_f [$];
    int         exp_done;
    int         model_rr;
    int         b0, d0, e0;

    function automatic int script_len(input int r);
        return (r == 0) ? 3 : 5;
    endfunction

    function automatic logic [7:0] script_at(input int r, input int i);
        return (r == 0) ? S0[i] : S1[i];
    endfunction

    task automatic model_serve(input logic [1:0] mask);
        int r;
        for (int k = 0; k < 2; k++) begin
            r = (model_rr + k) % 2;
            if (mask[r]) begin
                for (int i = 0; i < script_len(r); i++) begin
                    exp_b.push_back(script_at(r, i));
                    exp_g.push_back(r);
                    exp_f.push_back(i == 0);
                end
                exp_done++;
            end
        end
        for (int k = 1; k >= 0; k--) begin
            r = (model_rr + k) % 2;
            if (mask[r]) begin
                model_rr = (r + 1) % 2;
                break;
            end
        end
    endtask

    task automatic start_test();
        b0 = got_b.size();
        d0 = done_c.size();
        e0 = err_c.size();
        exp_b.delete();
        exp_g.delete();
        exp_f.delete();
        exp_done = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [1:0] mask);
        req = mask;
        tick(1);
        req = 2'b00;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_c.size() - d0 < exp_done && n < budget) begin
            tick(1);
            n++;
        end
        check({tag, "_done_count"}, done_c.size() - d0, exp_done);
    endtask

    // Byte-by-byte comparison; with tx_ready high the accept spacing follows the state sequence:
    // 3 cycles within a script, 7 across back-to-back scripts, plus the settle gap after a CR.
    task automatic compare(input string tag, input bit timing);
        int n_got = got_b.size() - b0;
        int n = (n_got < exp_b.size()) ? n_got : exp_b.size();
        check({tag, "_nbytes"}, n_got, exp_b.size());
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_byte%0d", tag, i), got_b[b0 + i], exp_b[i]);
            check($sformatf("%s_gid%0d", tag, i), got_g[b0 + i], exp_g[i]);
            if (timing && i > 0) begin
                check($sformatf("%s_spacing%0d", tag, i), got_c[b0 + i] - got_c[b0 + i - 1],
                      (exp_f[i] ? 7 : 3) + ((exp_b[i - 1] == CR) ? D : 0));
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        model_rr = 0;
        tick(2);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rise;
        logic [1:0] mask;
        model_rr = 0;
        exp_done = 0;

        // Reset state
        tick(3);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_grant", grant_id, 0);
        rst_n = 1'b1;
        tick(2);

        // 1: single requester, gap after CR before done
        start_test();
        model_serve(2'b01);
        pulse(2'b01);
        wait_done("t1", 200);
        tick(5);
        compare("t1", 1'b1);
        if (got_b.size() > b0 && done_c.size() > d0)
            check("t1_done_latency", done_c[d0] - got_c[got_b.size() - 1], D + 3);

        // 2: simultaneous requests from rr=0
        do_reset();
        start_test();
        model_serve(2'b11);
        pulse(2'b11);
        wait_done("t2", 400);
        tick(20);
        compare("t2", 1'b1);

        // 3: back-pressure on the second byte
        start_test();
        model_serve(2'b01);
        pulse(2'b01);
        n = 0;
        while (!(tx_valid === 1'b1 && tx_data === 8'h54) && n < 50) begin
            tick(1);
            n++;
        end
        tx_ready = 1'b0;
        check("t3_reach_54", {tx_valid, tx_data}, {1'b1, 8'h54});
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check($sformatf("t3_hold_valid%0d", i), tx_valid, 1);
            check($sformatf("t3_hold_data%0d", i), tx_data, 8'h54);
        end
        tx_ready = 1'b1;
        wait_done("t3", 200);
        tick(5);
        compare("t3", 1'b0);

        // 4: repeated requests while running coalesce into one extra run
        start_test();
        model_serve(2'b01);
        model_serve(2'b01);
        pulse(2'b01);
        tick(4);
        pulse(2'b01);
        tick(3);
        pulse(2'b01);
        tick(5);
        check("t4_busy_at_pulse", busy, 1);
        pulse(2'b01);
        wait_done("t4", 400);
        tick(30);
        compare("t4", 1'b1);

        // 5: reset in the middle of the settle gap
        start_test();
        for (int i = 0; i < 4; i++) begin
            exp_b.push_back(script_at(1, i));
            exp_g.push_back(1);
            exp_f.push_back(i == 0);
        end
        pulse(2'b10);
        n = 0;
        while (got_b.size() - b0 < 4 && n < 100) begin
            tick(1);
            n++;
        end
        tick(4);
        check("t5_busy_in_gap", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_tx_valid", tx_valid, 0);
        check("t5_rst_tx_data", tx_data, 0);
        check("t5_rst_grant", grant_id, 0);
        check("t5_rst_done", done, 0);
        tick(2);
        rst_n = 1'b1;
        model_rr = 0;
        tick(30);
        compare("t5", 1'b0);
        check("t5_no_done", done_c.size() - d0, 0);
        check("t5_idle_busy", busy, 0);

        // 6: tx_ready stuck low
        start_test();
        tx_ready = 1'b0;
        pulse(2'b01);
        n = 0;
        while (tx_valid !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        rise = cyc;
        check("t6_valid_rose", tx_valid, 1);
`ifdef GSM_SCHED_TIMEOUT_EN
        model_rr = 1;
        n = 0;
        while (err_c.size() == e0 && n < 60) begin
            tick(1);
            n++;
        end
        check("t6_err_seen", err_c.size() - e0, 1);
        if (err_c.size() > e0) check("t6_err_latency", err_c[e0] - rise, TO);
        check("t6_busy_after_err", busy, 0);
        check("t6_valid_after_err", tx_valid, 0);
        tx_ready = 1'b1;
        tick(30);
        check("t6_no_done", done_c.size() - d0, 0);
        compare("t6", 1'b0);
`else
        tick(50);
        check("t6_wait_valid", tx_valid, 1);
        check("t6_wait_data", tx_data, 8'h41);
        check("t6_wait_busy", busy, 1);
        check("t6_wait_err", err, 0);
        check("t6_wait_no_done", done_c.size() - d0, 0);
        model_serve(2'b01);
        tx_ready = 1'b1;
        wait_done("t6", 200);
        tick(5);
        compare("t6", 1'b0);
`endif

        // 7: randomized request sets with random back-pressure
        for (int round = 0; round < 6; round++) begin
            start_test();
            mask = 2'($urandom_range(1, 3));
            model_serve(mask);
            pulse(mask);
            n = 0;
            while (done_c.size() - d0 < exp_done && n < 1500) begin
                tx_ready = ($urandom_range(0, 3) != 0);
                tick(1);
                n++;
            end
            tx_ready = 1'b1;
            check($sformatf("t7_r%0d_done_count", round), done_c.size() - d0, exp_done);
            tick(5);
            compare($sformatf("t7_r%0d", round), 1'b0);
        end

        check("protocol_violations", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
